// File: rtl/lock_pkg.sv
// ============================================================================
// Module : lock_pkg
// Brief  : Shared lock-controller types: blink FSM encoding, blink types,
//          controller compare types and a counter-width helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_DONE = 2'd3
    } blink_state_e;

    localparam logic BLINK_LONG  = 1'b0;
    localparam logic BLINK_SHORT = 1'b1;

    localparam logic [1:0] CMP_USER_CODE   = 2'd0;
    localparam logic [1:0] CMP_MASTER_CODE = 2'd1;
    localparam logic [1:0] CMP_NEW_CODE    = 2'd2;

    // Counters run 0..max_val-1, so $clog2(max_val) bits suffice (min 1 bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module : tick_prescaler
// Brief  : Divides hwclk into a one-cycle tick every TICK_DIV cycles.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int unsigned TICK_DIV = 1200000
) (
    input  logic hwclk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned             c_cnt_w = lock_pkg::cnt_width(TICK_DIV);
    localparam logic [c_cnt_w-1:0]      c_last  = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == c_last)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == c_last);

endmodule

`default_nettype wire

// File: rtl/blink_sequencer.sv
// ============================================================================
// Module : blink_sequencer
// Brief  : Generates the long/short LED blink waveform for the lock controller
//          and flags completion while the request is still held.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module blink_sequencer
    import lock_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 1200000,
    parameter int unsigned LONG_ON_TICKS   = 5,
    parameter int unsigned LONG_OFF_TICKS  = 5,
    parameter int unsigned LONG_COUNT      = 2,
    parameter int unsigned SHORT_ON_TICKS  = 1,
    parameter int unsigned SHORT_OFF_TICKS = 1,
    parameter int unsigned SHORT_COUNT     = 5
) (
    input  logic hwclk,
    input  logic rst_n,
    input  logic start_blinking,
    input  logic blinkType,
    output logic ledblink,
    output logic done_blinking,
    output logic busy
);

    localparam int unsigned c_long_max  = (LONG_ON_TICKS  > LONG_OFF_TICKS)  ? LONG_ON_TICKS  : LONG_OFF_TICKS;
    localparam int unsigned c_short_max = (SHORT_ON_TICKS > SHORT_OFF_TICKS) ? SHORT_ON_TICKS : SHORT_OFF_TICKS;
    localparam int unsigned c_tick_max  = (c_long_max > c_short_max) ? c_long_max : c_short_max;
    localparam int unsigned c_blink_max = (LONG_COUNT > SHORT_COUNT) ? LONG_COUNT : SHORT_COUNT;
    localparam int unsigned c_tick_w    = cnt_width(c_tick_max);
    localparam int unsigned c_blink_w   = cnt_width(c_blink_max);

    localparam logic [c_tick_w-1:0]  c_long_on_last   = c_tick_w'(LONG_ON_TICKS - 1);
    localparam logic [c_tick_w-1:0]  c_long_off_last  = c_tick_w'(LONG_OFF_TICKS - 1);
    localparam logic [c_tick_w-1:0]  c_short_on_last  = c_tick_w'(SHORT_ON_TICKS - 1);
    localparam logic [c_tick_w-1:0]  c_short_off_last = c_tick_w'(SHORT_OFF_TICKS - 1);
    localparam logic [c_blink_w-1:0] c_long_cnt_last  = c_blink_w'(LONG_COUNT - 1);
    localparam logic [c_blink_w-1:0] c_short_cnt_last = c_blink_w'(SHORT_COUNT - 1);

    blink_state_e         state_q, state_d;
    logic                 type_q, type_d;
    logic [c_tick_w-1:0]  tick_cnt_q, tick_cnt_d;
    logic [c_blink_w-1:0] blink_cnt_q, blink_cnt_d;
    logic                 ledblink_q, done_q, busy_q;

    logic                 w_tick;
    logic                 w_clr;
    logic [c_tick_w-1:0]  w_on_last;
    logic [c_tick_w-1:0]  w_off_last;
    logic [c_blink_w-1:0] w_cnt_last;

    assign w_on_last  = (type_q == BLINK_SHORT) ? c_short_on_last  : c_long_on_last;
    assign w_off_last = (type_q == BLINK_SHORT) ? c_short_off_last : c_long_off_last;
    assign w_cnt_last = (type_q == BLINK_SHORT) ? c_short_cnt_last : c_long_cnt_last;

    // Restarting the prescaler on every state change keeps phases exact multiples of TICK_DIV.
    assign w_clr = (state_d != state_q);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .hwclk (hwclk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        tick_cnt_d  = tick_cnt_q;
        blink_cnt_d = blink_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_blinking) begin
                    type_d      = blinkType;
                    tick_cnt_d  = '0;
                    blink_cnt_d = '0;
                    state_d     = ST_ON;
                end
            end
            ST_ON: begin
                if (!start_blinking) begin
                    state_d = ST_IDLE;
                end else if (w_tick) begin
                    if (tick_cnt_q == w_on_last) begin
                        tick_cnt_d = '0;
                        state_d    = ST_OFF;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            ST_OFF: begin
                if (!start_blinking) begin
                    state_d = ST_IDLE;
                end else if (w_tick) begin
                    if (tick_cnt_q == w_off_last) begin
                        tick_cnt_d = '0;
                        if (blink_cnt_q == w_cnt_last) begin
                            state_d = ST_DONE;
                        end else begin
                            blink_cnt_d = blink_cnt_q + 1'b1;
                            state_d     = ST_ON;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (!start_blinking) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as state.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            type_q      <= BLINK_LONG;
            tick_cnt_q  <= '0;
            blink_cnt_q <= '0;
            ledblink_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            tick_cnt_q  <= tick_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            ledblink_q  <= (state_d == ST_ON);
            done_q      <= (state_d == ST_DONE);
            busy_q      <= (state_d == ST_ON) || (state_d == ST_OFF);
        end
    end

    assign ledblink      = ledblink_q;
    assign done_blinking = done_q;
    assign busy          = busy_q;

endmodule

`default_nettype wire
